// File: rtl/csr_init_seq.sv
// CSR file initialisation sequencer: walks every entry after reset (or on request)
// and writes its init value, optionally skipping zero entries at one cycle each.
module csr_init_seq #(
  parameter int NUM_REGS  = 256,
  parameter int XLEN      = 64,
  parameter bit SKIP_ZERO = 1'b1,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REGS*XLEN-1:0] init_vals,
  input  logic                     init_req,
  output logic                     wr_valid,
  output logic [IDX_W-1:0]         wr_idx,
  output logic [XLEN-1:0]          wr_data,
  input  logic                     wr_ready,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W:0]           init_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

  function automatic logic [XLEN-1:0] entry_val(input logic [NUM_REGS*XLEN-1:0] vals,
                                                input logic [IDX_W-1:0] i);
    return vals[int'(i) * XLEN +: XLEN];
  endfunction

  function automatic logic is_skip(input logic [XLEN-1:0] v);
    return SKIP_ZERO && (v == {XLEN{1'b0}});
  endfunction

  state_t           state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [IDX_W:0]   count_r, count_s;
  logic             wr_valid_r, wr_valid_s;
  logic             busy_r, done_r;
  logic             fire_s;

  // Next-state, index and count decode; wr_valid is looked ahead from the next index
  // so a freshly loaded entry is presented in the same cycle it becomes current.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    count_s = count_r;
    fire_s  = wr_valid_r & wr_ready;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_LOAD;
        idx_s   = {IDX_W{1'b0}};
        count_s = {(IDX_W+1){1'b0}};
      end
      ST_LOAD: begin
        if (fire_s) begin
          count_s = count_r + CNT_ONE;
        end else begin
          count_s = count_r;
        end
        // A low wr_valid in LOAD only ever means the current entry is being skipped.
        if (fire_s || !wr_valid_r) begin
          if (idx_r == LAST_IDX) begin
            state_s = ST_DONE;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      ST_DONE: begin
        if (init_req) begin
          state_s = ST_LOAD;
          idx_s   = {IDX_W{1'b0}};
          count_s = {(IDX_W+1){1'b0}};
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = {IDX_W{1'b0}};
        count_s = {(IDX_W+1){1'b0}};
      end
    endcase
    if (state_s == ST_LOAD) begin
      wr_valid_s = !is_skip(entry_val(init_vals, idx_s));
    end else begin
      wr_valid_s = 1'b0;
    end
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= {IDX_W{1'b0}};
      count_r    <= {(IDX_W+1){1'b0}};
      wr_valid_r <= 1'b0;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      count_r    <= count_s;
      wr_valid_r <= wr_valid_s;
      busy_r     <= (state_s != ST_DONE);
      done_r     <= (state_s == ST_DONE);
    end
  end

  assign wr_valid   = wr_valid_r;
  assign wr_idx     = idx_r;
  assign wr_data    = entry_val(init_vals, idx_r);
  assign busy       = busy_r;
  assign done       = done_r;
  assign init_count = count_r;

endmodule

// File: tb/tb_csr_init_seq.sv
// Directed bench for csr_init_seq: one instance writing every entry, one skipping zeros.
module tb_csr_init_seq;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [W-1:0]   vals_a [N];
  logic [W-1:0]   vals_b [N];
  logic [N*W-1:0] init_a, init_b;
  logic           req_a, req_b, rdy_a, rdy_b;
  logic           val_a, val_b, busy_a, busy_b, done_a, done_b;
  logic [IW-1:0]  idx_a, idx_b;
  logic [W-1:0]   dat_a, dat_b;
  logic [IW:0]    cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign init_a[g*W +: W] = vals_a[g];
    assign init_b[g*W +: W] = vals_b[g];
  end

  csr_init_seq #(.NUM_REGS(N), .XLEN(W), .SKIP_ZERO(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_vals(init_a), .init_req(req_a),
    .wr_valid(val_a), .wr_idx(idx_a), .wr_data(dat_a), .wr_ready(rdy_a),
    .busy(busy_a), .done(done_a), .init_count(cnt_a)
  );

  csr_init_seq #(.NUM_REGS(N), .XLEN(W), .SKIP_ZERO(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_vals(init_b), .init_req(req_b),
    .wr_valid(val_b), .wr_idx(idx_b), .wr_data(dat_b), .wr_ready(rdy_b),
    .busy(busy_b), .done(done_b), .init_count(cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_a_valid"}, 64'(val_a), 64'd0);
    check({tag, "_a_idx"},   64'(idx_a), 64'd0);
    check({tag, "_a_busy"},  64'(busy_a), 64'd1);
    check({tag, "_a_done"},  64'(done_a), 64'd0);
    check({tag, "_a_count"}, 64'(cnt_a), 64'd0);
    check({tag, "_b_valid"}, 64'(val_b), 64'd0);
    check({tag, "_b_busy"},  64'(busy_b), 64'd1);
    check({tag, "_b_done"},  64'(done_b), 64'd0);
    check({tag, "_b_count"}, 64'(cnt_b), 64'd0);
  endtask

  // Checks one full pass with wr_ready high, starting at the first LOAD cycle.
  task automatic pass_ab(input bit do_a, input bit do_b, input int req_at);
    int exp_b;
    exp_b = 0;
    for (int k = 0; k < N; k++) begin
      if (do_a) begin
        check($sformatf("a_valid[%0d]", k), 64'(val_a), 64'd1);
        check($sformatf("a_idx[%0d]", k),   64'(idx_a), 64'(k));
        check($sformatf("a_data[%0d]", k),  64'(dat_a), 64'(vals_a[k]));
        check($sformatf("a_count[%0d]", k), 64'(cnt_a), 64'(k));
        check($sformatf("a_busy[%0d]", k),  64'(busy_a), 64'd1);
        check($sformatf("a_done[%0d]", k),  64'(done_a), 64'd0);
      end
      if (do_b) begin
        check($sformatf("b_valid[%0d]", k), 64'(val_b), 64'(vals_b[k] != 16'h0));
        if (vals_b[k] != 16'h0) begin
          check($sformatf("b_idx[%0d]", k),  64'(idx_b), 64'(k));
          check($sformatf("b_data[%0d]", k), 64'(dat_b), 64'(vals_b[k]));
        end
        check($sformatf("b_count[%0d]", k), 64'(cnt_b), 64'(exp_b));
        check($sformatf("b_busy[%0d]", k),  64'(busy_b), 64'd1);
        check($sformatf("b_done[%0d]", k),  64'(done_b), 64'd0);
        if (vals_b[k] != 16'h0) exp_b++;
      end
      if (k == req_at) begin
        req_a = do_a;
        req_b = do_b;
      end
      step();
      req_a = 1'b0;
      req_b = 1'b0;
    end
    if (do_a) begin
      check("a_end_done",  64'(done_a), 64'd1);
      check("a_end_busy",  64'(busy_a), 64'd0);
      check("a_end_valid", 64'(val_a), 64'd0);
      check("a_end_count", 64'(cnt_a), 64'd8);
    end
    if (do_b) begin
      check("b_end_done",  64'(done_b), 64'd1);
      check("b_end_busy",  64'(busy_b), 64'd0);
      check("b_end_valid", 64'(val_b), 64'd0);
      check("b_end_count", 64'(cnt_b), 64'(exp_b));
    end
  endtask

  initial begin
    int ei;
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    for (int i = 0; i < N; i++) begin
      vals_a[i] = 16'h1000 + 16'(i);
      vals_b[i] = 16'h0;
    end
    vals_b[2] = 16'h0005;
    vals_b[5] = 16'h000A;

    repeat (2) step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();
    pass_ab(1'b1, 1'b1, -1);

    // Re-run from DONE; an init_req inside LOAD must not disturb the pass.
    req_a = 1'b1;
    req_b = 1'b1;
    step();
    req_a = 1'b0;
    req_b = 1'b0;
    pass_ab(1'b1, 1'b1, 3);

    // Stall three cycles at index 3 on the write-all instance.
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    for (int c = 0; c < 11; c++) begin
      ei = (c < 3) ? c : ((c < 6) ? 3 : c - 3);
      check($sformatf("stall_valid[%0d]", c), 64'(val_a), 64'd1);
      check($sformatf("stall_idx[%0d]", c),   64'(idx_a), 64'(ei));
      check($sformatf("stall_data[%0d]", c),  64'(dat_a), 64'(vals_a[ei]));
      check($sformatf("stall_count[%0d]", c), 64'(cnt_a), 64'(ei));
      check($sformatf("idle_b_valid[%0d]", c), 64'(val_b), 64'd0);
      rdy_a = (c >= 3 && c < 6) ? 1'b0 : 1'b1;
      rdy_b = c[0];
      step();
    end
    rdy_b = 1'b1;
    check("stall_end_done",  64'(done_a), 64'd1);
    check("stall_end_valid", 64'(val_a), 64'd0);
    check("stall_end_count", 64'(cnt_a), 64'd8);
    check("idle_b_done",     64'(done_b), 64'd1);
    check("idle_b_count",    64'(cnt_b), 64'd2);

    // Reset in the middle of a pass, then full restart on both instances.
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pre_rst_idx[%0d]", k), 64'(idx_a), 64'(k));
      step();
    end
    check("pre_rst_idx4",   64'(idx_a), 64'd4);
    check("pre_rst_valid4", 64'(val_a), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    step();
    chk_reset("held_rst");
    rst_n = 1'b1;
    step();
    pass_ab(1'b1, 1'b1, -1);

    // All-zero table on the skipping instance: no writes at all.
    for (int i = 0; i < N; i++) vals_b[i] = 16'h0;
    req_b = 1'b1;
    step();
    req_b = 1'b0;
    pass_ab(1'b0, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_init_seq.md
CSR_INIT_SEQ -- requirements
Module: csr_init_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 256, number of CSR file entries to initialise.
REQ-002 SHALL have parameter XLEN, default 64, CSR data width.
REQ-003 SHALL have parameter SKIP_ZERO, default 1; 1 = write only entries with nonzero init value, 0 = write every entry.
REQ-004 SHALL have derived parameter IDX_W = $clog2(NUM_REGS).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 init_vals  in  NUM_REGS x XLEN  per-entry init values; quasi-static, stable from reset release until done.
REQ-008 init_req  in  1  single-cycle request to re-run initialisation, e.g. soft reset.
REQ-009 wr_valid  out  1  write request to CSR file.
REQ-010 wr_idx  out  IDX_W  internal CSR index being written.
REQ-011 wr_data  out  XLEN  value being written, equal to init_vals[wr_idx].
REQ-012 wr_ready  in  1  CSR file accepts write this cycle.
REQ-013 busy  out  1  initialisation pass in progress; hart held.
REQ-014 done  out  1  last pass complete.
REQ-015 init_count  out  IDX_W+1  number of writes accepted in current/last pass.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DONE; IDLE is the reset state.
REQ-017 IDLE -> LOAD unconditionally on the first rising clk after rst_n deasserts; idx cleared to 0.
REQ-018 In LOAD, when SKIP_ZERO=1 and init_vals[idx]==0, SHALL keep wr_valid=0 and advance idx by 1 that cycle, one cycle per skipped entry.
REQ-019 In LOAD, otherwise, SHALL assert wr_valid with wr_idx=idx, wr_data=init_vals[idx].
REQ-020 wr_valid, wr_idx, wr_data SHALL be held stable until handshake (wr_valid & wr_ready); wr_valid never drops without handshake.
REQ-021 On handshake, SHALL increment init_count by 1 and advance idx by 1.
REQ-022 When idx==NUM_REGS-1 advances (by handshake or skip), SHALL go to DONE next cycle; idx SHALL NOT wrap inside LOAD.
REQ-023 wr_valid SHALL deassert in the cycle after the final handshake; no write issued in IDLE or DONE.
REQ-024 busy SHALL be 1 in IDLE and LOAD, 0 in DONE; done SHALL be 1 only in DONE.
REQ-025 init_req in DONE SHALL move to LOAD next cycle with idx=0, init_count=0, done=0, busy=1.
REQ-026 init_req in IDLE or LOAD SHALL be ignored; the current pass completes unchanged.
REQ-027 wr_ready while wr_valid=0 SHALL have no effect.
REQ-028 Pass latency with wr_ready tied high: exactly NUM_REGS LOAD cycles, independent of SKIP_ZERO.
REQ-029 init_count SHALL saturate-free count to NUM_REGS; width IDX_W+1 guarantees no overflow.
REQ-030 FSM state, idx, init_count, wr_valid SHALL be registers; wr_data SHALL be decoded from registered idx.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, idx=0, init_count=0, wr_valid=0, busy=1, done=0.
REQ-032 Reset asserted mid-LOAD SHALL abort the pass; after release the pass restarts from idx 0 with no partial state retained.

Verification
REQ-033 NUM_REGS=8, SKIP_ZERO=0, wr_ready=1 -> writes idx 0..7 on 8 consecutive cycles; done=1 the cycle after idx 7 handshake; init_count=8.
REQ-034 NUM_REGS=8, SKIP_ZERO=1, init_vals[2]=0x5, init_vals[5]=0xA, rest 0 -> exactly two writes: (2,0x5) then (5,0xA); done after 8 LOAD cycles; init_count=2.
REQ-035 SKIP_ZERO=0, wr_ready low 3 cycles while wr_idx=3 -> wr_valid=1, wr_idx=3, wr_data unchanged for all 3 cycles; pass ends 3 cycles later than REQ-033.
REQ-036 In DONE, pulse init_req -> second full pass with identical write sequence; done low throughout, init_count restarts at 0.
REQ-037 rst_n pulsed low while wr_idx=4 -> outputs at reset values during reset; after release first write is idx 0.
REQ-038 SKIP_ZERO=1, all init_vals zero -> wr_valid never asserted; done after NUM_REGS LOAD cycles; init_count=0.
